// File: rtl/posi_mode_scheduler_pkg.sv
// Shared constants and types for the posi-stage intra mode search.
package posi_mode_scheduler_pkg;

  // Candidate modes evaluated per PU and datapath widths.
  localparam int POSI_NUM_MODES = 35;
  localparam int POSI_DIST_W    = 16;
  localparam int POSI_RATE_W    = 13;
  // One extra bit over the distortion holds max distortion + max rate.
  localparam int POSI_COST_W    = POSI_DIST_W + 1;
  localparam int POSI_MODE_W    = 6;
  localparam int POSI_POS_W     = 8;

  // PU size codes shared with the rate estimator.
  typedef enum logic [1:0] {
    SIZE_04 = 2'd0,
    SIZE_08 = 2'd1,
    SIZE_16 = 2'd2,
    SIZE_32 = 2'd3
  } pu_size_e;

endpackage

// File: rtl/posi_mode_scheduler_cost_cmp.sv
// Cost adder and strict-less comparator for one candidate mode.
module posi_cost_cmp #(
  parameter int DIST_W = 16,
  parameter int RATE_W = 13,
  parameter int COST_W = 17
) (
  input  logic [DIST_W-1:0] dist_i,
  input  logic [RATE_W-1:0] rate_i,
  input  logic [COST_W-1:0] best_cost_i,
  output logic [COST_W-1:0] cost_o,
  output logic              upd_o
);

  // Zero-extended sum cannot wrap at COST_W; strict less keeps the lower mode on ties.
  always_comb begin
    cost_o = COST_W'(dist_i) + COST_W'(rate_i);
    upd_o  = (cost_o < best_cost_i);
  end

endmodule

// File: rtl/posi_mode_scheduler.sv
// Sequences the candidate-mode search for one PU: request a distortion per
// mode, add the rate estimate, keep the cheapest mode, then replay it once.
module posi_mode_scheduler
  import posi_mode_scheduler_pkg::*;
#(
  parameter int NUM_MODES = POSI_NUM_MODES,
  parameter int DIST_W    = POSI_DIST_W,
  parameter int RATE_W    = POSI_RATE_W,
  parameter int COST_W    = POSI_COST_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [1:0]             size_i,
  input  logic [POSI_POS_W-1:0]  position_i,
  output logic [POSI_MODE_W-1:0] mode_o,
  output logic [1:0]             size_o,
  output logic [POSI_POS_W-1:0]  position_o,
  output logic                   cost_done_o,
  input  logic [RATE_W-1:0]      bitrate_i,
  output logic                   dist_req_o,
  input  logic                   dist_val_i,
  input  logic [DIST_W-1:0]      dist_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [POSI_MODE_W-1:0] best_mode_o,
  output logic [COST_W-1:0]      best_cost_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_UPD  = 2'd3
  } state_e;

  localparam logic [POSI_MODE_W-1:0] LAST_MODE = POSI_MODE_W'(NUM_MODES - 1);

  state_e                   state_q, state_d;
  logic [POSI_MODE_W-1:0]   mode_q, mode_d;
  logic [1:0]               size_q, size_d;
  logic [POSI_POS_W-1:0]    position_q, position_d;
  logic [POSI_MODE_W-1:0]   best_mode_q, best_mode_d;
  logic [COST_W-1:0]        best_cost_q, best_cost_d;

  logic [COST_W-1:0]        cost;
  logic                     cost_upd;

  posi_cost_cmp #(
    .DIST_W (DIST_W),
    .RATE_W (RATE_W),
    .COST_W (COST_W)
  ) u_cost_cmp (
    .dist_i      (dist_i),
    .rate_i      (bitrate_i),
    .best_cost_i (best_cost_q),
    .cost_o      (cost),
    .upd_o       (cost_upd)
  );

  // Next-state and datapath updates; every register holds unless its state acts on it.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    size_d      = size_q;
    position_d  = position_q;
    best_mode_d = best_mode_q;
    best_cost_d = best_cost_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          size_d      = size_i;
          position_d  = position_i;
          mode_d      = '0;
          best_cost_d = '1;
          best_mode_d = '0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dist_val_i) begin
          if (cost_upd) begin
            best_cost_d = cost;
            best_mode_d = mode_q;
          end
          if (mode_q == LAST_MODE) begin
            // Replay the winner, which may be the mode just evaluated.
            mode_d  = cost_upd ? mode_q : best_mode_q;
            state_d = ST_UPD;
          end else begin
            mode_d  = mode_q + POSI_MODE_W'(1);
            state_d = ST_REQ;
          end
        end
      end
      ST_UPD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      size_q      <= '0;
      position_q  <= '0;
      best_mode_q <= '0;
      best_cost_q <= '1;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      size_q      <= size_d;
      position_q  <= position_d;
      best_mode_q <= best_mode_d;
      best_cost_q <= best_cost_d;
    end
  end

  // Strobes decode directly from the registered state, so they are glitch-free.
  always_comb begin
    dist_req_o  = (state_q == ST_REQ);
    cost_done_o = (state_q == ST_UPD);
    done_o      = (state_q == ST_UPD);
    busy_o      = (state_q != ST_IDLE);
    mode_o      = mode_q;
    size_o      = size_q;
    position_o  = position_q;
    best_mode_o = best_mode_q;
    best_cost_o = best_cost_q;
  end

endmodule

// File: tb/tb_posi_mode_scheduler.sv
// Self-checking bench for posi_mode_scheduler: models the rate estimator and
// distortion engine, and compares results with an argmin reference.
module tb_posi_mode_scheduler;
  import posi_mode_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  size_i;
  logic [7:0]  position_i;
  logic [5:0]  mode_o;
  logic [1:0]  size_o;
  logic [7:0]  position_o;
  logic        cost_done_o;
  logic [12:0] bitrate_i;
  logic        dist_req_o;
  logic        dist_val_i;
  logic [15:0] dist_i;
  logic        busy_o;
  logic        done_o;
  logic [5:0]  best_mode_o;
  logic [16:0] best_cost_o;

  logic [15:0] dist_tab [0:63];
  logic [12:0] rate_tab [0:63];

  int errors = 0;
  int checks = 0;

  // Distortion engine model state.
  int   lat_min = 1;
  int   lat_max = 1;
  bit   spur_en = 1'b0;
  int   req_cnt = 0;
  int   seq_err = 0;
  bit   pend    = 1'b0;
  int   cnt     = 0;
  logic [5:0] req_mode = '0;

  always #5 clk = ~clk;

  // Rate estimator: combinational lookup on the presented mode.
  assign bitrate_i = rate_tab[mode_o];

  posi_mode_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .size_i      (size_i),
    .position_i  (position_i),
    .mode_o      (mode_o),
    .size_o      (size_o),
    .position_o  (position_o),
    .cost_done_o (cost_done_o),
    .bitrate_i   (bitrate_i),
    .dist_req_o  (dist_req_o),
    .dist_val_i  (dist_val_i),
    .dist_i      (dist_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .best_mode_o (best_mode_o),
    .best_cost_o (best_cost_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Distortion engine: answers each request after a random latency, and may
  // inject stray valids while no request is outstanding.
  initial begin
    dist_val_i = 1'b0;
    dist_i     = '0;
    forever begin
      @(negedge clk);
      dist_val_i = 1'b0;
      dist_i     = '0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          dist_val_i = 1'b1;
          dist_i     = dist_tab[req_mode];
          pend       = 1'b0;
        end
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        dist_val_i = 1'b1;
        dist_i     = 16'($urandom_range(0, 20));
      end
      if (dist_req_o) begin
        if (mode_o != 6'(req_cnt)) seq_err++;
        req_cnt++;
        req_mode = mode_o;
        pend     = 1'b1;
        cnt      = $urandom_range(lat_min, lat_max);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_mode"},      32'(mode_o),      32'd0);
    check({tag, "_size"},      32'(size_o),      32'd0);
    check({tag, "_pos"},       32'(position_o),  32'd0);
    check({tag, "_bmode"},     32'(best_mode_o), 32'd0);
    check({tag, "_bcost"},     32'(best_cost_o), 32'h1FFFF);
    check({tag, "_busy"},      32'(busy_o),      32'd0);
    check({tag, "_done"},      32'(done_o),      32'd0);
    check({tag, "_cost_done"}, 32'(cost_done_o), 32'd0);
    check({tag, "_req"},       32'(dist_req_o),  32'd0);
  endtask

  // Reference: strict-less argmin of dist+rate over the modes in order.
  task automatic model(output int bm, output int bc);
    bm = 0;
    bc = 32'h1FFFF;
    for (int m = 0; m < POSI_NUM_MODES; m++) begin
      int c;
      c = int'(dist_tab[m]) + int'(rate_tab[m]);
      if (c < bc) begin
        bc = c;
        bm = m;
      end
    end
  endtask

  task automatic run(input string tag, input logic [1:0] sz, input logic [7:0] pos,
                     input bit spur_start, input int exp_cyc);
    int  bm, bc, cyc;
    bit  seen;
    model(bm, bc);
    @(negedge clk);
    req_cnt    = 0;
    seq_err    = 0;
    start_i    = 1'b1;
    size_i     = sz;
    position_i = pos;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      start_i = 1'b0;
      cyc++;
      if (done_o) begin
        seen = 1'b1;
      end else if (spur_start && $urandom_range(0, 7) == 0) begin
        start_i    = 1'b1;
        size_i     = 2'($urandom);
        position_i = 8'($urandom);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      if (exp_cyc > 0) check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_cost_done"}, 32'(cost_done_o), 32'd1);
      check({tag, "_replay_mode"}, 32'(mode_o), 32'(bm));
      check({tag, "_best_mode"}, 32'(best_mode_o), 32'(bm));
      check({tag, "_best_cost"}, 32'(best_cost_o), 32'(bc));
      check({tag, "_size"}, 32'(size_o), 32'(sz));
      check({tag, "_pos"}, 32'(position_o), 32'(pos));
      check({tag, "_busy_at_done"}, 32'(busy_o), 32'd1);
      check({tag, "_req_count"}, 32'(req_cnt), 32'(POSI_NUM_MODES));
      check({tag, "_mode_order"}, 32'(seq_err), 32'd0);
      @(negedge clk);
      start_i = 1'b0;
      check({tag, "_done_drop"}, 32'(done_o), 32'd0);
      check({tag, "_cost_done_drop"}, 32'(cost_done_o), 32'd0);
      check({tag, "_busy_drop"}, 32'(busy_o), 32'd0);
      check({tag, "_hold_mode"}, 32'(best_mode_o), 32'(bm));
      check({tag, "_hold_cost"}, 32'(best_cost_o), 32'(bc));
    end
    start_i = 1'b0;
  endtask

  initial begin
    int wait_cyc;
    rst        = 1'b1;
    start_i    = 1'b0;
    size_i     = '0;
    position_i = '0;
    for (int m = 0; m < 64; m++) begin
      dist_tab[m] = '0;
      rate_tab[m] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    // Flat distortion and rate: mode 0 wins, minimum latency.
    for (int m = 0; m < 64; m++) begin
      dist_tab[m] = 16'd100;
      rate_tab[m] = 13'd40;
    end
    run("flat", SIZE_04, 8'h12, 1'b0, 71);

    // Single low distortion at mode 26.
    for (int m = 0; m < 64; m++) begin
      dist_tab[m] = 16'd500;
      rate_tab[m] = 13'd10;
    end
    dist_tab[26] = 16'd40;
    run("mode26", SIZE_08, 8'h40, 1'b0, 71);

    // Tie at cost 50 between modes 5 and 9.
    for (int m = 0; m < 64; m++) begin
      dist_tab[m] = 16'd200;
      rate_tab[m] = 13'd100;
    end
    dist_tab[5] = 16'd30; rate_tab[5] = 13'd20;
    dist_tab[9] = 16'd20; rate_tab[9] = 13'd30;
    run("tie", SIZE_16, 8'h05, 1'b0, 71);

    // Random data, random latency, stray valids and starts while busy.
    lat_min = 1;
    lat_max = 21;
    spur_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int m = 0; m < 64; m++) begin
        dist_tab[m] = 16'($urandom_range(0, 300));
        rate_tab[m] = 13'($urandom_range(0, 60));
      end
      run($sformatf("rand%0d", r), 2'(r + 1), 8'($urandom), 1'b1, 0);
    end
    spur_en = 1'b0;

    // Reset while waiting on mode 17's distortion; the late valid must be ignored.
    lat_min = 6;
    lat_max = 6;
    for (int m = 0; m < 64; m++) begin
      dist_tab[m] = 16'($urandom_range(0, 300));
      rate_tab[m] = 13'd3;
    end
    dist_tab[2] = 16'd0;
    @(negedge clk);
    req_cnt    = 0;
    seq_err    = 0;
    start_i    = 1'b1;
    size_i     = SIZE_32;
    position_i = 8'hA5;
    wait_cyc   = 0;
    @(negedge clk);
    start_i = 1'b0;
    while (!(req_cnt == 18 && busy_o && !dist_req_o) && wait_cyc < 1000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("rst17_reached", 32'(req_cnt), 32'd18);
    check("rst17_mode", 32'(mode_o), 32'd17);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("rst17");
    repeat (10) @(negedge clk);
    check("rst17_late_busy", 32'(busy_o), 32'd0);
    check("rst17_late_cost", 32'(best_cost_o), 32'h1FFFF);
    lat_min = 1;
    lat_max = 1;
    run("after_rst", SIZE_04, 8'h33, 1'b0, 71);

    // Saturating inputs: cost must not wrap.
    for (int m = 0; m < 64; m++) begin
      dist_tab[m] = 16'hFFFF;
      rate_tab[m] = 13'h1FFF;
    end
    run("maxval", SIZE_08, 8'hFF, 1'b0, 71);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
